// File: rtl/cbd_stream.sv
// rtl/cbd_stream.sv - streaming centered-binomial sampler, noise words in, coefficient beats out
//
// Noise bits are appended to a small shift buffer above the current fill.
// Each output beat consumes the low 2*ETA*LANES bits and turns every
// 2*ETA-bit group into popcount(low half) - popcount(high half).
module cbd_stream #(
  parameter int ETA     = 2,
  parameter int IN_W    = 32,
  parameter int LANES   = 4,
  parameter int MODQ    = 0,
  parameter int COEFF_W = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IN_W-1:0]            in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*COEFF_W-1:0]   out_coeff,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done
);

  localparam int GB     = 2 * ETA * LANES;
  localparam int BUF_W  = IN_W + GB;
  localparam int WORDS  = 512 * ETA / IN_W;
  localparam int BEATS  = 256 / LANES;
  localparam int FILL_W = $clog2(BUF_W + 1);
  localparam int WCNT_W = $clog2(WORDS + 1);
  localparam int BCNT_W = $clog2(BEATS + 1);

  localparam logic [COEFF_W-1:0] Q_VAL = COEFF_W'(3329);

  localparam bit PARAMS_OK =
      (ETA == 2 || ETA == 3) &&
      (IN_W == 8 || IN_W == 16 || IN_W == 32 || IN_W == 64) &&
      (LANES >= 1) && (LANES <= 16) && ((LANES & (LANES - 1)) == 0) &&
      (256 % LANES == 0) && ((512 * ETA) % IN_W == 0) &&
      ((MODQ == 0 && COEFF_W >= 4) || (MODQ == 1 && COEFF_W == 12));

  if (!PARAMS_OK) begin : g_param_check
    $error("cbd_stream: illegal parameter combination");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state_q, state_d;
  logic [BUF_W-1:0]     buf_q, buf_shift, buf_d, word_ext;
  logic [FILL_W-1:0]    fill_q, fill_drain, fill_d;
  logic [WCNT_W-1:0]    words_left_q;
  logic [BCNT_W-1:0]    beats_left_q;
  logic [LANES*COEFF_W-1:0] coeff_d;
  logic                 accept, load, final_hs, running;

  logic [2*ETA-1:0]          grp;
  logic [3:0]                pa, pb;
  logic signed [3:0]         diff;
  logic signed [COEFF_W-1:0] sx;

  assign running  = (state_q == RUN);
  assign busy     = running;
  assign in_ready = running && (words_left_q != '0) &&
                    (fill_q <= FILL_W'(BUF_W - IN_W));
  assign accept   = in_valid && in_ready;
  assign load     = running && (fill_q >= FILL_W'(GB)) && (beats_left_q != '0) &&
                    (!out_valid || out_ready);
  assign final_hs = out_valid && out_ready && out_last;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: start only matters in IDLE, last handshake ends the polynomial
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (final_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Buffer next value: drain first, then append the word at the drained fill
  always_comb begin
    buf_shift  = load ? (buf_q >> GB) : buf_q;
    fill_drain = load ? (fill_q - FILL_W'(GB)) : fill_q;
    word_ext   = BUF_W'(in_data) << fill_drain;
    buf_d      = buf_shift;
    fill_d     = fill_drain;
    if (accept) begin
      buf_d  = buf_shift | word_ext;
      fill_d = fill_drain + FILL_W'(IN_W);
    end
  end

  // Per-lane popcount difference, sign-extended or lifted into [0, q-1]
  always_comb begin
    coeff_d = '0;
    grp     = '0;
    pa      = '0;
    pb      = '0;
    diff    = '0;
    sx      = '0;
    for (int k = 0; k < LANES; k++) begin
      grp = buf_q[k*2*ETA +: 2*ETA];
      pa  = '0;
      pb  = '0;
      for (int j = 0; j < ETA; j++) begin
        pa = pa + 4'(grp[j]);
        pb = pb + 4'(grp[ETA+j]);
      end
      diff = signed'(pa - pb);
      sx   = COEFF_W'(diff);
      if (MODQ != 0 && diff < 0) sx = signed'(sx + Q_VAL);
      coeff_d[k*COEFF_W +: COEFF_W] = sx;
    end
  end

  // Bit buffer, fill and word/beat counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q        <= '0;
      fill_q       <= '0;
      words_left_q <= '0;
      beats_left_q <= '0;
    end else if (!running) begin
      buf_q  <= '0;
      fill_q <= '0;
      if (start) begin
        words_left_q <= WCNT_W'(WORDS);
        beats_left_q <= BCNT_W'(BEATS);
      end
    end else if (final_hs) begin
      buf_q        <= '0;
      fill_q       <= '0;
      words_left_q <= '0;
      beats_left_q <= '0;
    end else begin
      buf_q  <= buf_d;
      fill_q <= fill_d;
      if (accept) words_left_q <= words_left_q - WCNT_W'(1);
      if (load)   beats_left_q <= beats_left_q - BCNT_W'(1);
    end
  end

  // One-stage output register; holds while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_coeff <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_coeff <= coeff_d;
      out_last  <= (beats_left_q == BCNT_W'(1));
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

  // done pulses the cycle after the final beat handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done <= 1'b0;
    else        done <= final_hs;
  end

endmodule

// File: tb/tb_cbd_stream.sv
// tb/tb_cbd_stream.sv - scoreboard bench for cbd_stream (default and ETA=3 mod-q builds)
module tb_cbd_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start, in_valid, in_ready, out_valid, out_ready, out_last, busy, done;
  logic [31:0] in_data;
  logic [15:0] out_coeff;

  logic        start3, iv3, ir3, ov3, or3, ol3, busy3, done3;
  logic [63:0] id3;
  logic [95:0] oc3;

  int total = 0, bad = 0, cyc = 0;
  int beats_seen = 0, done_cnt = 0, acc_cnt = 0, last_cyc = 0;
  int beats3 = 0, done3_cnt = 0, first_acc3 = -1, first_ov3 = -1;
  bit abort = 0, hold_after = 0;
  logic [16:0] sbq[$];
  logic [96:0] q3[$];
  logic [16:0] e;
  logic [96:0] e3;
  logic [15:0] h;
  int prev;

  cbd_stream dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_coeff(out_coeff),
    .out_last(out_last), .busy(busy), .done(done)
  );

  cbd_stream #(.ETA(3), .IN_W(64), .LANES(8), .MODQ(1), .COEFF_W(12)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .in_valid(iv3), .in_ready(ir3),
    .in_data(id3), .out_valid(ov3), .out_ready(or3), .out_coeff(oc3),
    .out_last(ol3), .busy(busy3), .done(done3)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor for the default build
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) acc_cnt++;
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) chk("sb_underflow", sbq.size(), 1);
        else begin
          e = sbq.pop_front();
          chk("beat_coeff", out_coeff, e[15:0]);
          chk("beat_last", out_last, e[16]);
        end
        beats_seen++;
        if (out_last) last_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        chk("done_latency", cyc, last_cyc + 1);
        chk("busy_at_done", busy, 0);
        chk("in_ready_at_done", in_ready, 0);
      end
    end
  end

  // Scoreboard monitor for the ETA=3 mod-q build
  always @(negedge clk) begin
    if (rst_n) begin
      if (iv3 && ir3 && first_acc3 < 0) first_acc3 = cyc;
      if (ov3 && first_ov3 < 0) first_ov3 = cyc;
      if (ov3 && or3) begin
        if (q3.size() == 0) chk("sb3_underflow", q3.size(), 1);
        else begin
          e3 = q3.pop_front();
          chk("beat3_coeff", oc3, e3[95:0]);
          chk("beat3_last", ol3, e3[96]);
        end
        beats3++;
      end
      if (done3) done3_cnt++;
    end
  end

  function automatic logic [15:0] beat16(input logic [15:0] x);
    logic [15:0] r;
    int a, b, d;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      a = int'(x[4*k]) + int'(x[4*k+1]);
      b = int'(x[4*k+2]) + int'(x[4*k+3]);
      d = a - b;
      r[4*k +: 4] = d[3:0];
    end
    return r;
  endfunction

  function automatic logic [31:0] word_val(input int kind, input int i);
    case (kind)
      0:       return 32'h0000_0000;
      1:       return 32'hC3C3_C3C3;
      default: return 32'h0123_4567 + 32'(i) * 32'h9E37_79B9;
    endcase
  endfunction

  function automatic logic [63:0] w3(input int i);
    logic [63:0] r;
    for (int j = 0; j < 64; j++) r[j] = (((i * 64 + j) % 6) >= 3);
    return r;
  endfunction

  task automatic push_poly(input int kind);
    logic [31:0] w;
    logic [15:0] lo, hi;
    for (int i = 0; i < 32; i++) begin
      w = word_val(kind, i);
      if (kind == 0)      begin lo = 16'h0000; hi = 16'h0000; end
      else if (kind == 1) begin lo = 16'hE2E2; hi = 16'hE2E2; end
      else begin lo = beat16(w[15:0]); hi = beat16(w[31:16]); end
      sbq.push_back({1'b0, lo});
      sbq.push_back({(i == 31), hi});
    end
  endtask

  task automatic send_word(input logic [31:0] d);
    int n;
    bit ok;
    n = 0; ok = 0;
    in_valid = 1'b1; in_data = d;
    while (!ok && !abort && n < 2000) begin
      @(negedge clk); ok = in_ready; n++;
      @(posedge clk); #1;
    end
    if (!ok && !abort) chk("word_accept_timeout", n, 0);
  endtask

  task automatic send3(input logic [63:0] d);
    int n;
    bit ok;
    n = 0; ok = 0;
    iv3 = 1'b1; id3 = d;
    while (!ok && n < 2000) begin
      @(negedge clk); ok = ir3; n++;
      @(posedge clk); #1;
    end
    if (!ok) chk("word3_accept_timeout", n, 0);
  endtask

  task automatic feed(input int kind);
    for (int i = 0; i < 32 && !abort; i++) send_word(word_val(kind, i));
    if (hold_after && !abort) begin in_valid = 1'b1; in_data = 32'hDEAD_BEEF; end
    else in_valid = 1'b0;
  endtask

  task automatic do_start;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int p);
    int n;
    n = 0;
    while (done_cnt == p && n < 3000) begin @(posedge clk); #1; n++; end
    chk("done_count", done_cnt, p + 1);
  endtask

  task automatic wait_beats(input int k);
    int n;
    n = 0;
    while (beats_seen < k && n < 2000) begin @(posedge clk); #1; n++; end
    chk("reach_beats", beats_seen >= k, 1);
  endtask

  task automatic end_poly(input int p);
    wait_done(p);
    chk("beat_total", beats_seen, 64);
    chk("sb_drained", sbq.size(), 0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_coeff"}, out_coeff, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  initial begin
    rst_n = 0; start = 0; in_valid = 0; in_data = '0; out_ready = 1;
    start3 = 0; iv3 = 0; id3 = '0; or3 = 1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs("rst");
    rst_n = 1;
    @(posedge clk); #1;

    // all-zero noise
    beats_seen = 0; prev = done_cnt;
    push_poly(0);
    do_start;
    chk("busy_after_start", busy, 1);
    chk("in_ready_after_start", in_ready, 1);
    feed(0);
    end_poly(prev);

    // C3 pattern: alternating +2 / -2
    beats_seen = 0; prev = done_cnt;
    push_poly(1);
    do_start;
    feed(1);
    end_poly(prev);

    // ETA=3, 64-bit words, mod-q: every coefficient is -3 -> 3326
    for (int i = 0; i < 32; i++) q3.push_back({(i == 31), {8{12'd3326}}});
    @(posedge clk); #1 start3 = 1'b1;
    @(posedge clk); #1 start3 = 1'b0;
    for (int i = 0; i < 24; i++) send3(w3(i));
    iv3 = 1'b0;
    for (int n = 0; n < 500 && done3_cnt == 0; n++) begin @(posedge clk); #1; end
    chk("eta3_done", done3_cnt, 1);
    chk("eta3_beats", beats3, 32);
    chk("eta3_sb_drained", q3.size(), 0);
    chk("eta3_latency", first_ov3 - first_acc3, 2);

    // consumer stall mid-stream
    beats_seen = 0; prev = done_cnt;
    push_poly(2);
    do_start;
    fork
      feed(2);
      begin
        wait_beats(10);
        out_ready = 1'b0;
        @(negedge clk);
        h = out_coeff;
        chk("stall_valid", out_valid, 1);
        repeat (19) begin
          @(negedge clk);
          chk("stall_hold", out_coeff, h);
        end
        chk("stall_in_ready_low", in_ready, 0);
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    end_poly(prev);

    // reset mid-polynomial, then a clean rerun
    beats_seen = 0; prev = done_cnt;
    push_poly(2);
    do_start;
    fork
      feed(2);
      begin
        wait_beats(10);
        rst_n = 1'b0; abort = 1'b1;
        #1;
        chk_reset_outs("abort");
      end
    join
    sbq.delete();
    in_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1; abort = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("no_done_after_abort", done_cnt, prev);
    beats_seen = 0;
    push_poly(2);
    do_start;
    feed(2);
    end_poly(prev);

    // second start during RUN and in_valid held past the last word
    beats_seen = 0; acc_cnt = 0; prev = done_cnt; hold_after = 1;
    push_poly(2);
    do_start;
    fork
      feed(2);
      begin
        repeat (6) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
      end
    join
    end_poly(prev);
    repeat (10) @(posedge clk);
    #1;
    chk("accepted_words", acc_cnt, 32);
    chk("single_done", done_cnt, prev + 1);
    hold_after = 0; in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
